vram_port_arbiter: RTL and testbench

Shares the single VRAM port among the video scanout and up to N_REQ drawing requesters, such as the rectangle drawers for the frame and target. Scanout has absolute priority while the active-video window is open. Drawing requesters get the port during blanking under round-robin arbitration with a bounded burst length. The block sits between the drawing engines and the single-port `sram` instance, and returns read data to whichever agent issued the read.

---
 rtl/vram_pkg.sv | 15 +
 rtl/rr_select.sv | 27 ++
 rtl/vram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM geometry and arbiter state encoding.
package vram_pkg;

    localparam int SCREEN_WIDTH  = 800;
    localparam int SCREEN_HEIGHT = 600;
    localparam int VRAM_A_WIDTH  = 19;
    localparam int VRAM_D_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        OWN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Cyclic first-set search over a request vector, starting at ptr.
module rr_select #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                sel[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single VRAM port shared by scanout (active video) and round-robin
// drawing requesters (blanking), with read data routed back by tag.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_WIDTH = VRAM_A_WIDTH,
    parameter int DATA_WIDTH = VRAM_D_WIDTH,
    parameter int N_REQ      = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic                        clk,
    input  logic                        w_rst,
    input  logic                        i_active,
    input  logic [ADDR_WIDTH-1:0]       i_disp_addr,
    output logic [DATA_WIDTH-1:0]       o_disp_data,
    output logic                        o_disp_valid,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0]            i_wr,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic [N_REQ-1:0]            o_rvalid,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic                        o_mem_write,
    output logic [DATA_WIDTH-1:0]       o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]       i_mem_rdata
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t state, state_nx;
    logic [PW-1:0] r_owner, owner_nx, r_rr, rr_nx;
    logic [PW-1:0] owner_inc, sel_ptr, sel_idx;
    logic [BW-1:0] r_burst, burst_nx;
    logic [N_REQ-1:0] owner_oh, sel_req, sel_oh, rd_oh;
    logic sel_valid, xfer, owner_req, burst_end;

    logic [1:0]       tg_disp;
    logic [N_REQ-1:0] tg_rd [2];

    assign owner_oh  = N_REQ'(1) << r_owner;
    assign owner_inc = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign owner_req = |(i_req & owner_oh);
    assign burst_end = (r_burst == BURST_LAST);

    assign o_gnt = (state == OWN && !i_active) ? owner_oh : '0;
    assign xfer  = |(o_gnt & i_req);
    assign rd_oh = o_gnt & i_req & ~i_wr;

    // In OWN the search starts past the owner and ignores the owner itself
    assign sel_ptr = (state == OWN) ? owner_inc : r_rr;
    assign sel_req = (state == OWN) ? (i_req & ~owner_oh) : i_req;

    rr_select #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req   (sel_req),
        .ptr   (sel_ptr),
        .sel   (sel_oh),
        .valid (sel_valid)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (sel_oh[i]) sel_idx = PW'(i);
    end

    always_comb begin
        state_nx = state;
        owner_nx = r_owner;
        rr_nx    = r_rr;
        burst_nx = r_burst;
        unique case (state)
            IDLE, DISP: begin
                if (i_active) begin
                    state_nx = DISP;
                end else if (sel_valid) begin
                    state_nx = OWN;
                    owner_nx = sel_idx;
                    burst_nx = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            OWN: begin
                if (i_active) begin
                    state_nx = DISP;
                    burst_nx = '0;
                    if (owner_req && burst_end) rr_nx = owner_inc;
                end else if (!owner_req) begin
                    rr_nx    = owner_inc;
                    burst_nx = '0;
                    if (sel_valid) owner_nx = sel_idx;
                    else state_nx = IDLE;
                end else if (burst_end) begin
                    burst_nx = '0;
                    if (sel_valid) begin
                        rr_nx    = owner_inc;
                        owner_nx = sel_idx;
                    end
                end else begin
                    burst_nx = r_burst + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            state   <= IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_burst <= '0;
        end else begin
            state   <= state_nx;
            r_owner <= owner_nx;
            r_rr    <= rr_nx;
            r_burst <= burst_nx;
        end
    end

    // Port mux plus a two-deep read tag matching the sram read latency
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            o_mem_addr   <= '0;
            o_mem_write  <= 1'b0;
            o_mem_wdata  <= '0;
            tg_disp      <= '0;
            tg_rd[0]     <= '0;
            tg_rd[1]     <= '0;
            o_disp_valid <= 1'b0;
            o_rvalid     <= '0;
            o_disp_data  <= '0;
            o_rdata      <= '0;
        end else begin
            if (i_active) begin
                o_mem_addr  <= i_disp_addr;
                o_mem_write <= 1'b0;
            end else if (xfer) begin
                o_mem_addr  <= i_addr[int'(r_owner)*ADDR_WIDTH +: ADDR_WIDTH];
                o_mem_write <= i_wr[r_owner];
                o_mem_wdata <= i_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                o_mem_write <= 1'b0;
            end
            tg_disp      <= {tg_disp[0], i_active};
            tg_rd[0]     <= rd_oh;
            tg_rd[1]     <= tg_rd[0];
            o_disp_valid <= tg_disp[1];
            o_rvalid     <= tg_rd[1];
            if (tg_disp[1]) o_disp_data <= i_mem_rdata;
            if (|tg_rd[1]) o_rdata <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench: scripted transactions, sram model, read-return scoreboard.
module tb_vram_port_arbiter;

    logic        clk = 1'b0;
    logic        w_rst;
    logic        i_active;
    logic [18:0] i_disp_addr;
    logic [3:0]  o_disp_data;
    logic        o_disp_valid;
    logic [1:0]  i_req;
    logic [1:0]  i_wr;
    logic [37:0] i_addr;
    logic [7:0]  i_data;
    logic [1:0]  o_gnt;
    logic [3:0]  o_rdata;
    logic [1:0]  o_rvalid;
    logic [18:0] o_mem_addr;
    logic        o_mem_write;
    logic [3:0]  o_mem_wdata;
    logic [3:0]  i_mem_rdata;

    typedef struct {
        int         cyc;
        logic       disp;
        logic [1:0] rv;
        logic [3:0] data;
    } sb_item_t;

    sb_item_t sb [$];
    int cyc = 0;
    int n_chk = 0;
    int n_bad = 0;
    logic [3:0] vram [0:4095];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (o_mem_write) vram[o_mem_addr[11:0]] <= o_mem_wdata;
        i_mem_rdata <= vram[o_mem_addr[11:0]];
    end

    vram_port_arbiter #(
        .ADDR_WIDTH (19),
        .DATA_WIDTH (4),
        .N_REQ      (2),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .w_rst        (w_rst),
        .i_active     (i_active),
        .i_disp_addr  (i_disp_addr),
        .o_disp_data  (o_disp_data),
        .o_disp_valid (o_disp_valid),
        .i_req        (i_req),
        .i_wr         (i_wr),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .o_gnt        (o_gnt),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_write  (o_mem_write),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic d, input logic [1:0] rv,
                        input logic [3:0] v);
        sb_item_t e;
        e.cyc = c; e.disp = d; e.rv = rv; e.data = v;
        sb.push_back(e);
    endtask

    task automatic mon_step();
        sb_item_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("rd_missing", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (o_disp_valid || (|o_rvalid)) begin
            if (sb.size() == 0) begin
                chk("rd_spurious", {o_disp_valid, o_rvalid}, 0);
            end else begin
                e = sb.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_valid", {o_disp_valid, o_rvalid}, {e.disp, e.rv});
                chk("rd_data", e.disp ? o_disp_data : o_rdata, e.data);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon_step();
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input int r, input logic w, input logic [18:0] a,
                         input logic [3:0] d);
        i_req[r] = 1'b1;
        i_wr[r] = w;
        i_addr[r*19 +: 19] = a;
        i_data[r*4 +: 4] = d;
    endtask

    // Request from IDLE, expect grant next cycle, drop after one transfer
    task automatic one_xfer(input int r, input logic w, input logic [18:0] a,
                            input logic [3:0] d, input logic [3:0] exp_rd);
        next(); drive(r, w, a, d); mid();
        chk("gnt_pre", o_gnt, 0);
        next(); mid();
        chk("gnt_t1", o_gnt, 32'(1) << r);
        if (!w) push(cyc + 3, 1'b0, 2'(1 << r), exp_rd);
        next(); i_req = '0; mid();
        chk("mwr_t2", o_mem_write, w);
        chk("madr_t2", o_mem_addr, a);
        if (w) chk("mdat_t2", o_mem_wdata, d);
    endtask

    initial begin
        w_rst = 1'b1;
        i_active = 1'b0;
        i_disp_addr = '0;
        i_req = '0;
        i_wr = '0;
        i_addr = '0;
        i_data = '0;
        repeat (3) next();
        mid();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_mwr", o_mem_write, 0);
        chk("rst_madr", o_mem_addr, 0);
        chk("rst_mdat", o_mem_wdata, 0);
        chk("rst_rd", {o_rdata, o_disp_data}, 0);
        chk("rst_val", {o_rvalid, o_disp_valid}, 0);
        next(); w_rst = 1'b0;

        one_xfer(0, 1'b1, 19'd1234, 4'd9, 4'd0);
        next(); mid();
        chk("mwr_t3", o_mem_write, 0);
        one_xfer(0, 1'b1, 19'd50, 4'b0100, 4'd0);
        one_xfer(0, 1'b1, 19'd0, 4'd3, 4'd0);
        one_xfer(0, 1'b1, 19'd1, 4'd6, 4'd0);
        one_xfer(0, 1'b1, 19'd2, 4'd12, 4'd0);
        one_xfer(0, 1'b0, 19'd1234, 4'd0, 4'd9);
        one_xfer(1, 1'b0, 19'd50, 4'd0, 4'b0100);

        // Burst fairness, both requesters held, rr pointer at 0
        next(); drive(0, 1'b1, 19'd100, 4'd1); drive(1, 1'b1, 19'd200, 4'd2);
        mid();
        chk("fair_pre", o_gnt, 0);
        for (int k = 0; k < 12; k++) begin
            next(); mid();
            chk("fair_gnt", o_gnt, ((k / 4) % 2 == 0) ? 1 : 2);
            if (k > 0)
                chk("fair_madr", o_mem_addr,
                    (((k - 1) / 4) % 2 == 0) ? 100 : 200);
        end
        next(); i_req = '0; mid();
        chk("fair_last", o_mem_addr, 100);
        next(); mid();
        chk("fair_idle", o_mem_write, 0);

        // Scanout preempts req1 after two reads
        next(); drive(1, 1'b0, 19'd50, 4'd0); mid();
        chk("pre_p0", o_gnt, 0);
        next(); mid();
        chk("pre_p1", o_gnt, 2);
        push(cyc + 3, 1'b0, 2'b10, 4'd4);
        next(); mid();
        chk("pre_p2", o_gnt, 2);
        push(cyc + 3, 1'b0, 2'b10, 4'd4);
        next(); i_active = 1'b1; i_disp_addr = 19'd0; mid();
        chk("pre_gnt_drop", o_gnt, 0);
        push(cyc + 3, 1'b1, 2'b00, 4'd3);
        next(); i_disp_addr = 19'd1; mid();
        chk("pre_gnt_act", o_gnt, 0);
        chk("pre_madr0", o_mem_addr, 0);
        chk("pre_mwr", o_mem_write, 0);
        push(cyc + 3, 1'b1, 2'b00, 4'd6);
        next(); i_disp_addr = 19'd2; mid();
        chk("pre_madr1", o_mem_addr, 1);
        push(cyc + 3, 1'b1, 2'b00, 4'd12);
        next(); i_active = 1'b0; mid();
        chk("pre_fall", o_gnt, 0);
        next(); mid();
        chk("pre_resume", o_gnt, 2);
        push(cyc + 3, 1'b0, 2'b10, 4'd4);
        next(); i_req = '0;

        // Sole requester runs through several burst boundaries
        next(); drive(0, 1'b1, 19'd300, 4'd7); mid();
        chk("sole_pre", o_gnt, 0);
        for (int k = 0; k < 40; k++) begin
            next(); mid();
            chk("sole_gnt", o_gnt, 1);
        end
        next(); i_req = '0;

        // Reset while req0 owns the port with a read in flight
        next(); drive(0, 1'b0, 19'd50, 4'd0); mid();
        chk("rb_pre", o_gnt, 0);
        next(); mid();
        chk("rb_own", o_gnt, 1);
        next(); #2; w_rst = 1'b1; #1;
        chk("rb_gnt", o_gnt, 0);
        chk("rb_mwr", o_mem_write, 0);
        chk("rb_madr", o_mem_addr, 0);
        chk("rb_rd", {o_rdata, o_disp_data}, 0);
        chk("rb_val", {o_rvalid, o_disp_valid}, 0);
        next(); w_rst = 1'b0; mid();
        chk("rb_rel", o_gnt, 0);
        next(); mid();
        chk("rb_regnt", o_gnt, 1);
        push(cyc + 3, 1'b0, 2'b01, 4'd4);
        next(); i_req = '0;
        repeat (6) next();
        mid();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
